// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the microsequenced SAP control unit.
// UCODE_PARITY_EN adds an even-parity MSB to every microword.
package sap_ctrl_pkg;

  typedef enum logic [1:0] {
    SEQ_NEXT  = 2'b00,
    SEQ_DISP  = 2'b01,
    SEQ_END   = 2'b10,
    SEQ_CNEXT = 2'b11
  } seq_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

`ifdef UCODE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Width of the cond_sel field; never zero so a single flag still gets a field.
  function automatic int cond_w(input int nflag);
    return (nflag > 1) ? $clog2(nflag) : 1;
  endfunction

  // Default geometry and the microword field offsets that follow from it.
  localparam int DEF_CW_W    = 12;
  localparam int DEF_UADDR_W = 5;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_NFLAG   = 4;

  localparam int CW_LSB  = 0;
  localparam int CS_LSB  = CW_LSB + DEF_CW_W;
  localparam int SEQ_LSB = CS_LSB + cond_w(DEF_NFLAG);
  localparam int PAR_BIT = SEQ_LSB + 2;
  localparam int DEF_UW  = SEQ_LSB + 2 + PAR_W;

  // SAP datapath enables, bit positions within the 12-bit control word.
  localparam logic [11:0] PC_EN  = 12'h800;  // program counter onto bus
  localparam logic [11:0] PC_INC = 12'h400;  // program counter increment
  localparam logic [11:0] MAR_LD = 12'h200;  // memory address register load
  localparam logic [11:0] IR_OE  = 12'h100;  // instruction operand onto bus
  localparam logic [11:0] IR_LD  = 12'h080;  // instruction register load
  localparam logic [11:0] RAM_OE = 12'h040;  // RAM onto bus
  localparam logic [11:0] A_OE   = 12'h020;  // accumulator onto bus
  localparam logic [11:0] A_LD   = 12'h010;  // accumulator load
  localparam logic [11:0] B_LD   = 12'h008;  // B register load
  localparam logic [11:0] OUT_LD = 12'h004;  // output register load
  localparam logic [11:0] ALU_OE = 12'h002;  // ALU result onto bus
  localparam logic [11:0] SUB    = 12'h001;  // ALU subtract

endpackage

// File: rtl/microseq_store.sv
// Writable microcode RAM and opcode address map, both with async reads.
// Contents are never reset; software loads them before starting.
module microseq_store
  import sap_ctrl_pkg::*;
#(
  parameter int UW      = DEF_UW,
  parameter int UADDR_W = DEF_UADDR_W,
  parameter int OP_W    = DEF_OP_W
) (
  input  logic               sysclk,
  input  logic               prog_we,
  input  logic               prog_sel,
  input  logic [UADDR_W-1:0] prog_addr,
  input  logic [UW-1:0]      prog_data,
  input  logic [UADDR_W-1:0] rd_addr,
  input  logic [OP_W-1:0]    op,
  output logic [UW-1:0]      rd_word,
  output logic [UADDR_W-1:0] map_addr
);

  logic [UW-1:0]      urom [2**UADDR_W];
  logic [UADDR_W-1:0] amap [2**OP_W];

  // Programming port: prog_sel steers the write to the RAM or the map.
  always_ff @(posedge sysclk) begin
    if (prog_we && !prog_sel) urom[prog_addr] <= prog_data;
    if (prog_we && prog_sel)  amap[prog_addr[OP_W-1:0]] <= prog_data[UADDR_W-1:0];
  end

  assign rd_word  = urom[rd_addr];
  assign map_addr = amap[op];

endmodule

// File: rtl/microseq_ctrl.sv
// Writable-microcode sequencer replacing the hard-wired SAP-1 control unit.
// UCODE_PARITY_EN: microwords carry even parity; a bad word halts and sets uerr.
//
// state | meaning
// IDLE  | after reset, waiting for start; programming allowed
// RUN   | upc walks microcode on each clken_oop strobe
// HALT  | HALT_OP dispatched or parity error; only reset leaves
module microseq_ctrl
  import sap_ctrl_pkg::*;
#(
  parameter int              CW_W    = 12,
  parameter int              UADDR_W = 5,
  parameter int              OP_W    = 4,
  parameter int              NFLAG   = 4,
  parameter logic [OP_W-1:0] HALT_OP = OP_W'(4'hF),
  localparam int             CS_W    = cond_w(NFLAG),
  localparam int             UW      = CW_W + 2 + CS_W + PAR_W
) (
  input  logic               sysclk,
  input  logic               clear_n,
  input  logic               clken_oop,
  input  logic               start,
  input  logic [7:0]         ir,
  input  logic [NFLAG-1:0]   flags,
  input  logic               prog_we,
  input  logic               prog_sel,
  input  logic [UADDR_W-1:0] prog_addr,
  input  logic [UW-1:0]      prog_data,
  output logic [CW_W-1:0]    cword,
  output logic [UADDR_W-1:0] upc,
  output logic               running,
  output logic               halt,
  output logic               uerr
);

  localparam int FX_W = 2**CS_W;

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic               running_q, halt_q;
  logic [UW-1:0]      uword;
  logic [UADDR_W-1:0] map_addr;
  logic [OP_W-1:0]    opcode;
  logic [CW_W-1:0]    uw_cw;
  logic [CS_W-1:0]    uw_cs;
  seq_e               uw_seq;
  logic [FX_W-1:0]    flags_ext;
  logic               cond_ok;
  logic               par_err;
  logic               unused_ir;

  assign opcode    = ir[7 -: OP_W];
  assign unused_ir = ^ir[7-OP_W:0];

  microseq_store #(
    .UW      (UW),
    .UADDR_W (UADDR_W),
    .OP_W    (OP_W)
  ) u_store (
    .sysclk    (sysclk),
    .prog_we   (prog_we),
    .prog_sel  (prog_sel),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .rd_addr   (upc_q),
    .op        (opcode),
    .rd_word   (uword),
    .map_addr  (map_addr)
  );

  assign uw_cw  = uword[CW_W-1:0];
  assign uw_cs  = uword[CW_W +: CS_W];
  assign uw_seq = seq_e'(uword[CW_W+CS_W +: 2]);

  // Unimplemented cond_sel codes (NFLAG not a power of two) read as false.
  assign flags_ext = FX_W'(flags);
  assign cond_ok   = flags_ext[uw_cs];

`ifdef UCODE_PARITY_EN
  assign par_err = ^uword;
`else
  assign par_err = 1'b0;
`endif

  // State register; running/halt are registered copies of the next state.
  always_ff @(posedge sysclk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      upc_q     <= '0;
      running_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      running_q <= (state_d == RUN);
      halt_q    <= (state_d == HALT);
    end
  end

  // Next state and next micro-address; upc holds whenever the state halts.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          upc_d   = '0;
        end
      end
      RUN: begin
        if (clken_oop) begin
          if (par_err) begin
            state_d = HALT;
          end else begin
            case (uw_seq)
              SEQ_NEXT:  upc_d = upc_q + UADDR_W'(1);
              SEQ_DISP: begin
                if (opcode == HALT_OP) state_d = HALT;
                else                   upc_d   = map_addr;
              end
              SEQ_END:   upc_d = '0;
              SEQ_CNEXT: upc_d = cond_ok ? upc_q + UADDR_W'(1) : '0;
            endcase
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Control word reaches the datapath only while running.
  always_comb begin
    cword = '0;
    if (state_q == RUN) cword = uw_cw;
  end

`ifdef UCODE_PARITY_EN
  logic uerr_q;

  // Sticky parity error flag, cleared only by reset.
  always_ff @(posedge sysclk or negedge clear_n) begin
    if (!clear_n)                                      uerr_q <= 1'b0;
    else if (state_q == RUN && clken_oop && par_err)   uerr_q <= 1'b1;
  end

  assign uerr = uerr_q;
`else
  assign uerr = 1'b0;
`endif

  assign upc     = upc_q;
  assign running = running_q;
  assign halt    = halt_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Self-checking bench for microseq_ctrl: directed SAP-1 program plus
// randomized microcode/stimulus against a behavioural reference model.
module tb_microseq_ctrl;
  import sap_ctrl_pkg::*;

  localparam int CW_W    = DEF_CW_W;
  localparam int UADDR_W = DEF_UADDR_W;
  localparam int OP_W    = DEF_OP_W;
  localparam int NFLAG   = DEF_NFLAG;
  localparam int CS_W    = cond_w(NFLAG);
  localparam int UW      = CW_W + 2 + CS_W + PAR_W;
  localparam int NW      = 1 << UADDR_W;
  localparam int NOP     = 1 << OP_W;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

  logic               sysclk = 1'b0;
  logic               clear_n, clken_oop, start, prog_we, prog_sel;
  logic [7:0]         ir;
  logic [NFLAG-1:0]   flags;
  logic [UADDR_W-1:0] prog_addr;
  logic [UW-1:0]      prog_data;
  logic [CW_W-1:0]    cword;
  logic [UADDR_W-1:0] upc;
  logic               running, halt, uerr;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int                 m_mode;
  int                 m_upc;
  bit                 m_uerr;
  logic [UW-1:0]      m_rom [NW];
  logic [UADDR_W-1:0] m_map [NOP];

  microseq_ctrl dut (
    .sysclk    (sysclk),
    .clear_n   (clear_n),
    .clken_oop (clken_oop),
    .start     (start),
    .ir        (ir),
    .flags     (flags),
    .prog_we   (prog_we),
    .prog_sel  (prog_sel),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cword     (cword),
    .upc       (upc),
    .running   (running),
    .halt      (halt),
    .uerr      (uerr)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [UW-1:0] make_word(input int seq, input int cs, input int cw);
    logic [UW-1:0] w;
    w = '0;
    w[CW_W-1:0]         = cw[CW_W-1:0];
    w[CW_W +: CS_W]     = cs[CS_W-1:0];
    w[CW_W+CS_W +: 2]   = seq[1:0];
`ifdef UCODE_PARITY_EN
    w[UW-1] = ^w;
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_upc  = 0;
    m_uerr = 0;
  endtask

  // Apply one rising edge to the model using the inputs held across it.
  task automatic model_edge();
    logic [UW-1:0] w;
    int seq, cs, op;
    if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode = M_RUN;
        m_upc  = 0;
      end
    end else if (m_mode == M_RUN && clken_oop) begin
      w   = m_rom[m_upc];
      seq = int'(w >> (CW_W + CS_W)) & 3;
      cs  = int'(w >> CW_W) & ((1 << CS_W) - 1);
      op  = int'(ir) >> (8 - OP_W);
      if (PAR_W != 0 && (^w)) begin
        m_mode = M_HALTED;
        m_uerr = 1;
      end else begin
        case (seq)
          0: m_upc = (m_upc + 1) % NW;
          1: if (op == 15) m_mode = M_HALTED; else m_upc = int'(m_map[op]);
          2: m_upc = 0;
          default: m_upc = (cs < NFLAG && flags[cs]) ? (m_upc + 1) % NW : 0;
        endcase
      end
    end
    if (prog_we) begin
      if (prog_sel) m_map[int'(prog_addr) % NOP] = prog_data[UADDR_W-1:0];
      else          m_rom[prog_addr] = prog_data;
    end
  endtask

  task automatic compare_all();
    logic [CW_W-1:0] exp_cw;
    exp_cw = (m_mode == M_RUN) ? m_rom[m_upc][CW_W-1:0] : '0;
    chk("upc",     32'(upc),     32'(m_upc));
    chk("cword",   32'(cword),   32'(exp_cw));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("halt",    32'(halt),    32'(m_mode == M_HALTED));
    chk("uerr",    32'(uerr),    32'(m_uerr));
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Async reset asserted between edges, checked before any clock arrives.
  task automatic do_reset();
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_cword", 32'(cword), 32'h0);
    @(negedge sysclk);
    clear_n = 1'b1;
  endtask

  task automatic prog(input logic sel, input int addr, input logic [UW-1:0] data);
    prog_we   = 1'b1;
    prog_sel  = sel;
    prog_addr = UADDR_W'(addr);
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  int exp_upc [7] = '{0, 1, 2, 4, 5, 6, 0};
  int exp_cw  [7] = '{'hA00, 'h400, 'h0C0, 'h300, 'h050, 'h000, 'hA00};

  initial begin
    clear_n = 1'b0; clken_oop = 1'b0; start = 1'b0; ir = 8'h00; flags = '0;
    prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_data = '0;
    model_reset();
    #3;
    compare_all();
    @(negedge sysclk);
    clear_n = 1'b1;

    // SAP-1 fetch + LDA, a conditional pair at 20/21, a NEXT at the top address.
    for (int i = 0; i < NW; i++)  prog(1'b0, i, '0);
    for (int i = 0; i < NOP; i++) prog(1'b1, i, '0);
    prog(1'b0, 0,  make_word(0, 0, int'(PC_EN | MAR_LD)));
    prog(1'b0, 1,  make_word(0, 0, int'(PC_INC)));
    prog(1'b0, 2,  make_word(1, 0, int'(IR_LD | RAM_OE)));
    prog(1'b0, 4,  make_word(0, 0, int'(MAR_LD | IR_OE)));
    prog(1'b0, 5,  make_word(0, 0, int'(RAM_OE | A_LD)));
    prog(1'b0, 6,  make_word(2, 0, 0));
    prog(1'b0, 20, make_word(3, 0, 'h123));
    prog(1'b0, 21, make_word(2, 0, 'h321));
    prog(1'b0, 31, make_word(0, 0, 'h0FF));
    prog(1'b1, 0, UW'(4));
    prog(1'b1, 1, UW'(20));
    prog(1'b1, 2, UW'(31));

    // start and strobe together: RUN at upc 0, first advance on the next strobe
    ir = 8'h05; clken_oop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_run", 32'(running), 32'h1);
    chk("lda_upc0", 32'(upc), 32'(exp_upc[0]));
    chk("lda_cw0", 32'(cword), 32'(exp_cw[0]));
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("lda_upc", 32'(upc), 32'(exp_upc[i]));
      chk("lda_cw", 32'(cword), 32'(exp_cw[i]));
    end

    // stall mid-instruction, with a stray start that must be ignored
    tick(); tick(); tick();
    clken_oop = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_upc", 32'(upc), 32'h4);
      chk("stall_cw", 32'(cword), 32'h300);
    end
    clken_oop = 1'b1; start = 1'b0;
    tick(); tick(); tick();
    chk("resume_upc", 32'(upc), 32'h0);

    // CNEXT taken then not taken
    ir = 8'h10; flags = 4'b0001;
    tick(); tick(); tick();
    chk("cnext_at20", 32'(upc), 32'd20);
    tick();
    chk("cnext_taken", 32'(upc), 32'd21);
    tick(); tick(); tick(); tick();
    chk("cnext_again20", 32'(upc), 32'd20);
    flags = 4'b1110;
    tick();
    chk("cnext_fall", 32'(upc), 32'd0);

    // NEXT wraps from the top address
    ir = 8'h20;
    tick(); tick(); tick();
    chk("wrap_at31", 32'(upc), 32'd31);
    chk("wrap_cw31", 32'(cword), 32'h0FF);
    tick();
    chk("wrap_to0", 32'(upc), 32'd0);

    // HALT_OP dispatch is terminal
    ir = 8'hF0;
    tick(); tick(); tick();
    chk("halt_set", 32'(halt), 32'h1);
    chk("halt_cw", 32'(cword), 32'h0);
    chk("halt_upc", 32'(upc), 32'h2);
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    chk("halt_sticky", 32'(halt), 32'h1);
    chk("halt_upc_hold", 32'(upc), 32'h2);
    do_reset();
    chk("halt_clr", 32'(halt), 32'h0);

    // reset in the middle of RUN
    ir = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_cw", 32'(cword), 32'h400);
    do_reset();
    chk("mid_rst_run", 32'(running), 32'h0);

`ifdef UCODE_PARITY_EN
    prog(1'b0, 1, make_word(0, 0, int'(PC_INC)) ^ (UW'(1) << (UW - 1)));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("par_at1", 32'(upc), 32'h1);
    tick();
    chk("par_halt", 32'(halt), 32'h1);
    chk("par_uerr", 32'(uerr), 32'h1);
    chk("par_upc", 32'(upc), 32'h1);
    do_reset();
    chk("par_uerr_clr", 32'(uerr), 32'h0);
`endif

    // randomized microcode and stimulus
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < NW; i++) begin
        logic [UW-1:0] w;
        w = make_word(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom));
`ifdef UCODE_PARITY_EN
        if ($urandom_range(15) == 0) w[UW-1] = ~w[UW-1];
`endif
        prog(1'b0, i, w);
      end
      for (int i = 0; i < NOP; i++) prog(1'b1, i, UW'($urandom));
      for (int c = 0; c < 500; c++) begin
        start     = ($urandom_range(7) == 0);
        clken_oop = ($urandom_range(3) != 0);
        ir        = 8'($urandom);
        flags     = NFLAG'($urandom);
        prog_we   = ($urandom_range(15) == 0);
        prog_sel  = 1'($urandom);
        prog_addr = UADDR_W'($urandom);
        prog_data = UW'($urandom);
        tick();
        if (c % 125 == 124) begin
          prog_we = 1'b0;
          do_reset();
        end
      end
      prog_we = 1'b0;
      start   = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
